mac_norm_pipe: RTL and testbench

- Parametrised, multi-lane successor of the MAC stage-4 normaliser.
- Accepts LANES two's-complement partial sums per beat and produces, per lane:
  - leading-one-normalised magnitude,
  - signed exponent adjustment,
  - sign and zero flags.
- Max-exponent and Q_frac sideband travel alongside the data.
- Replaces the single-lane inhibit-stalled register with a 2-stage valid/ready pipeline: selectable rounding, flush, full backpressure.

---
 rtl/mac_norm_pipe.sv | 145 ++++++++++++++
 tb/tb_mac_norm_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_norm_pipe.sv
// mac_norm_pipe: multi-lane two-stage valid/ready leading-one normaliser for MAC partial sums
module mac_norm_pipe #(
    parameter int LANES    = 4,
    parameter int PSUM_W   = 19,
    parameter int NORM_W   = 11,
    parameter int FRAC_POS = 10,
    parameter int EXP_W    = 6,
    parameter int ADJ_W    = 6,
    parameter int SB_W     = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_flush,
    input  logic                      i_rnd_mode,
    input  logic [LANES*PSUM_W-1:0]   i_psum,
    input  logic [LANES*EXP_W-1:0]    i_max_exp,
    input  logic [SB_W-1:0]           i_Q_frac,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LANES*NORM_W-1:0]   o_norm_sum,
    output logic [LANES*ADJ_W-1:0]    o_exp_adj,
    output logic [LANES-1:0]          o_sgn,
    output logic [LANES-1:0]          o_zero,
    output logic [LANES*EXP_W-1:0]    o_max_exp,
    output logic [SB_W-1:0]           o_Q_frac
);

    typedef struct packed {
        logic              zero;
        logic              sgn;
        logic [ADJ_W-1:0]  adj;
        logic [NORM_W-1:0] norm;
    } lane_t;

    logic                    v1;
    logic                    rnd1;
    logic [LANES*PSUM_W-1:0] psum1;
    logic [LANES*EXP_W-1:0]  max_exp1;
    logic [SB_W-1:0]         q_frac1;
    logic                    adv1;
    logic                    adv2;
    logic [LANES*NORM_W-1:0] norm_c;
    logic [LANES*ADJ_W-1:0]  adj_c;
    logic [LANES-1:0]        sgn_c;
    logic [LANES-1:0]        zero_c;

    assign adv2    = ~o_valid | i_ready;
    assign adv1    = ~v1 | adv2;
    assign o_ready = adv1;

    function automatic lane_t norm_lane(input logic [PSUM_W-1:0] ps, input logic rnd);
        lane_t             r;
        logic [PSUM_W-1:0] mag;
        logic [PSUM_W-1:0] sh;
        logic [PSUM_W-1:0] mask;
        logic [NORM_W:0]   sum;
        logic              grd;
        logic              stk;
        int                p;
        r    = '0;
        mag  = ps[PSUM_W-1] ? -ps : ps;
        p    = 0;
        sh   = '0;
        mask = '0;
        sum  = '0;
        grd  = 1'b0;
        stk  = 1'b0;
        for (int i = 0; i < PSUM_W; i++)
            if (mag[i]) p = i;
        if (mag != '0) begin
            r.sgn = ps[PSUM_W-1];
            r.adj = ADJ_W'(p - FRAC_POS);
            if (p <= NORM_W - 1) begin
                sh     = mag << (NORM_W - 1 - p);
                r.norm = NORM_W'(sh);
            end else begin
                sh     = mag >> (p - NORM_W + 1);
                grd    = mag[p - NORM_W];
                mask   = (PSUM_W'(1) << (p - NORM_W)) - PSUM_W'(1);
                stk    = |(mag & mask);
                sum    = {1'b0, NORM_W'(sh)} + (NORM_W + 1)'(rnd & grd & (stk | sh[0]));
                r.norm = sum[NORM_W] ? NORM_W'(1) << (NORM_W - 1) : sum[NORM_W-1:0];
                r.adj  = r.adj + ADJ_W'(sum[NORM_W]);
            end
        end
        r.zero = (mag == '0);
        return r;
    endfunction

    // per-lane normalisation of the S1 contents
    always_comb begin
        norm_c = '0;
        adj_c  = '0;
        sgn_c  = '0;
        zero_c = '0;
        for (int k = 0; k < LANES; k++)
            {zero_c[k], sgn_c[k], adj_c[k*ADJ_W +: ADJ_W], norm_c[k*NORM_W +: NORM_W]} =
                norm_lane(psum1[k*PSUM_W +: PSUM_W], rnd1);
    end

    // S1: capture accepted beat, hold while stalled, cleared by flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1       <= 1'b0;
            rnd1     <= 1'b0;
            psum1    <= '0;
            max_exp1 <= '0;
            q_frac1  <= '0;
        end else begin
            v1 <= i_flush ? 1'b0 : adv1 ? i_valid : v1;
            if (adv1 && i_valid && !i_flush) begin
                rnd1     <= i_rnd_mode;
                psum1    <= i_psum;
                max_exp1 <= i_max_exp;
                q_frac1  <= i_Q_frac;
            end
        end
    end

    // S2: register normalised results with their sideband, hold while stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_norm_sum <= '0;
            o_exp_adj  <= '0;
            o_sgn      <= '0;
            o_zero     <= '0;
            o_max_exp  <= '0;
            o_Q_frac   <= '0;
        end else begin
            o_valid <= i_flush ? 1'b0 : adv2 ? v1 : o_valid;
            if (adv2 && v1) begin
                o_norm_sum <= norm_c;
                o_exp_adj  <= adj_c;
                o_sgn      <= sgn_c;
                o_zero     <= zero_c;
                o_max_exp  <= max_exp1;
                o_Q_frac   <= q_frac1;
            end
        end
    end

endmodule

// File: tb/tb_mac_norm_pipe.sv
// tb_mac_norm_pipe: randomized and directed checks of mac_norm_pipe against an arithmetic reference model
module tb_mac_norm_pipe;

    localparam int LANES = 4, PSUM_W = 19, NORM_W = 11, FRAC_POS = 10, EXP_W = 6, ADJ_W = 6, SB_W = 5;

    typedef struct packed {
        logic [LANES*NORM_W-1:0] norm;
        logic [LANES*ADJ_W-1:0]  adj;
        logic [LANES-1:0]        sgn;
        logic [LANES-1:0]        zero;
        logic [LANES*EXP_W-1:0]  mx;
        logic [SB_W-1:0]         qf;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    i_valid = 1'b0;
    logic                    o_ready;
    logic                    i_flush = 1'b0;
    logic                    i_rnd_mode = 1'b0;
    logic [LANES*PSUM_W-1:0] i_psum = '0;
    logic [LANES*EXP_W-1:0]  i_max_exp = '0;
    logic [SB_W-1:0]         i_Q_frac = '0;
    logic                    o_valid;
    logic                    i_ready = 1'b1;
    logic [LANES*NORM_W-1:0] o_norm_sum;
    logic [LANES*ADJ_W-1:0]  o_exp_adj;
    logic [LANES-1:0]        o_sgn;
    logic [LANES-1:0]        o_zero;
    logic [LANES*EXP_W-1:0]  o_max_exp;
    logic [SB_W-1:0]         o_Q_frac;

    int    checks = 0;
    int    failures = 0;
    int    pops = 0;
    bit    fired;
    bit    accepted;
    bit    saw_not_ready;
    bit    stall_prev = 0;
    logic [127:0] held;
    beat_t q[$];
    beat_t last;

    logic [PSUM_W-1:0] d_ps   [7] = '{19'h00400, 19'h7FFFF, 19'h40000, 19'h00FFF, 19'h00FFF, 19'h00801, 19'h00000};
    bit                d_rnd  [7] = '{0, 0, 0, 0, 1, 1, 0};
    logic [NORM_W-1:0] d_norm [7] = '{11'h400, 11'h400, 11'h400, 11'h7FF, 11'h400, 11'h400, 11'h000};
    logic [ADJ_W-1:0]  d_adj  [7] = '{6'h00, 6'h36, 6'h08, 6'h01, 6'h02, 6'h01, 6'h00};
    bit                d_sgn  [7] = '{0, 1, 1, 0, 0, 0, 0};
    bit                d_zero [7] = '{0, 0, 0, 0, 0, 0, 1};

    mac_norm_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_rnd_mode(i_rnd_mode), .i_psum(i_psum), .i_max_exp(i_max_exp), .i_Q_frac(i_Q_frac),
        .o_valid(o_valid), .i_ready(i_ready), .o_norm_sum(o_norm_sum), .o_exp_adj(o_exp_adj),
        .o_sgn(o_sgn), .o_zero(o_zero), .o_max_exp(o_max_exp), .o_Q_frac(o_Q_frac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // value-level model: real magnitude, integer division for the kept bits, remainder vs half for rounding
    function automatic void model_lane(input logic [PSUM_W-1:0] ps, input bit rnd,
                                       output logic [NORM_W-1:0] n, output logic [ADJ_W-1:0] a,
                                       output logic s, output logic z);
        int v, mag, p, sft, qt, rm, half, adj;
        v = int'($signed(ps));
        mag = v < 0 ? -v : v;
        n = '0; a = '0; s = 1'b0; z = 1'b0;
        if (mag == 0) begin
            z = 1'b1;
            return;
        end
        s = v < 0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        adj = p - FRAC_POS;
        if (p <= NORM_W - 1) qt = mag * (1 << (NORM_W - 1 - p));
        else begin
            sft  = p - (NORM_W - 1);
            qt   = mag / (1 << sft);
            rm   = mag % (1 << sft);
            half = 1 << (sft - 1);
            if (rnd && (rm > half || (rm == half && qt % 2 == 1))) qt++;
            if (qt == (1 << NORM_W)) begin
                qt = 1 << (NORM_W - 1);
                adj++;
            end
        end
        n = NORM_W'(qt);
        a = ADJ_W'(adj);
    endfunction

    function automatic beat_t model_beat();
        beat_t b;
        b = '0;
        for (int k = 0; k < LANES; k++)
            model_lane(i_psum[k*PSUM_W +: PSUM_W], i_rnd_mode, b.norm[k*NORM_W +: NORM_W],
                       b.adj[k*ADJ_W +: ADJ_W], b.sgn[k], b.zero[k]);
        b.mx = i_max_exp;
        b.qf = i_Q_frac;
        return b;
    endfunction

    function automatic logic [PSUM_W-1:0] rand_ps();
        logic [PSUM_W-1:0] x;
        x = PSUM_W'($urandom) >> $urandom_range(0, PSUM_W - 1);
        return $urandom_range(0, 1) ? -x : x;
    endfunction

    task automatic rand_inputs();
        for (int k = 0; k < LANES; k++) i_psum[k*PSUM_W +: PSUM_W] = rand_ps();
        i_max_exp  = (LANES*EXP_W)'({$urandom, $urandom});
        i_Q_frac   = SB_W'($urandom);
        i_rnd_mode = 1'($urandom);
    endtask

    function automatic logic [127:0] outs();
        return {o_valid, o_norm_sum, o_exp_adj, o_sgn, o_zero, o_max_exp, o_Q_frac};
    endfunction

    // one clock: observe at the falling edge, update scoreboard, then let the rising edge pass
    task automatic tick();
        @(negedge clk);
        fired = 0;
        accepted = 0;
        if (o_ready === 1'b0) saw_not_ready = 1;
        chk("o_ready", o_ready, !(q.size() == 2 && !i_ready));
        chk("spurious_valid", o_valid && q.size() == 0, 0);
        if (stall_prev) chk("stall_hold", outs(), held);
        if (i_flush) q.delete();
        else begin
            if (o_valid && i_ready && q.size() > 0) begin
                last = q.pop_front();
                chk("beat", {o_norm_sum, o_exp_adj, o_sgn, o_zero, o_max_exp, o_Q_frac}, last);
                fired = 1;
                pops++;
            end
            if (i_valid && o_ready) begin
                q.push_back(model_beat());
                accepted = 1;
            end
        end
        stall_prev = o_valid && !i_ready && !i_flush;
        held = outs();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        i_valid = 0;
        i_ready = 1;
        i_flush = 0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        rst_n = 1;
        @(negedge clk);
        chk("reset_ready", o_ready, 1);
        chk("reset_valid_data", outs(), 0);
        @(posedge clk);
        #1;

        for (int d = 0; d < 7; d++) begin
            rand_inputs();
            i_psum[PSUM_W-1:0] = d_ps[d];
            i_rnd_mode = d_rnd[d];
            i_valid = 1;
            tick();
            chk("dir_accept", accepted, 1);
            i_valid = 0;
            tick();
            chk("dir_early", fired, 0);
            tick();
            chk("dir_latency", fired, 1);
            chk("dir_norm", last.norm[NORM_W-1:0], d_norm[d]);
            chk("dir_adj", last.adj[ADJ_W-1:0], d_adj[d]);
            chk("dir_sgn", last.sgn[0], d_sgn[d]);
            chk("dir_zero", last.zero[0], d_zero[d]);
        end

        pops = 0;
        saw_not_ready = 0;
        begin
            int cyc;
            cyc = 0;
            for (int b = 0; b < 6; b++) begin
                rand_inputs();
                i_valid = 1;
                do begin
                    cyc++;
                    i_ready = !(cyc >= 3 && cyc <= 6);
                    tick();
                end while (!accepted && cyc < 40);
            end
        end
        drain();
        chk("bp_not_ready_seen", saw_not_ready, 1);
        chk("bp_beat_count", pops, 6);

        pops = 0;
        rand_inputs();
        i_valid = 1;
        tick();
        rand_inputs();
        tick();
        i_valid = 0;
        i_flush = 1;
        tick();
        i_flush = 0;
        @(negedge clk);
        chk("flush_valid", o_valid, 0);
        @(posedge clk);
        #1;
        repeat (4) tick();
        chk("flush_no_beats", pops, 0);

        rand_inputs();
        i_valid = 1;
        tick();
        rand_inputs();
        tick();
        i_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_outs", outs(), 0);
        q.delete();
        stall_prev = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("arst_ready", o_ready, 1);
        @(posedge clk);
        #1;
        pops = 0;
        repeat (4) tick();
        chk("arst_no_beats", pops, 0);

        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            i_valid = $urandom_range(0, 9) < 7;
            i_ready = $urandom_range(0, 9) < 7;
            i_flush = $urandom_range(0, 39) == 0;
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
